// File: rtl/suma_serial.sv
// Bit-serial M-bit adder: latches operands on start, adds one bit pair per cycle LSB first,
// then publishes the registered sum and C/N/V/Z flags with a one-cycle done pulse.
module suma_serial #(
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] A,
  input  logic [M-1:0] B,
  input  logic         cin,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] S,
  output logic         C,
  output logic         N,
  output logic         V,
  output logic         Z
);

  localparam int unsigned CntW = $clog2(M);
  localparam logic [CntW-1:0] LastBit = CntW'(M - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q, state_d;
  logic [M-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d, s_q, s_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic           c_q, c_d, n_q, n_d, v_q, v_d, z_q, z_d;
  logic           bit_sum, bit_carry;
  logic [M-1:0]   sum_next;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    s_d       = s_q;
    c_d       = c_q;
    n_d       = n_q;
    v_d       = v_q;
    z_d       = z_q;
    bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    // Sum bits enter at the MSB and shift down, so after M steps bit i sits at position i.
    sum_next  = {bit_sum, sum_q[M-1:1]};

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = cin;
          sum_d   = '0;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sum_d   = sum_next;
        carry_d = bit_carry;
        if (cnt_q == LastBit) begin
          // a_q[0]/b_q[0] hold the operand sign bits on this final step.
          s_d     = sum_next;
          c_d     = bit_carry;
          n_d     = bit_sum;
          v_d     = (a_q[0] == b_q[0]) && (bit_sum != a_q[0]);
          z_d     = (sum_next == '0);
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
      z_q     <= z_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign S    = s_q;
  assign C    = c_q;
  assign N    = n_q;
  assign V    = v_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_suma_serial.sv
// Randomized self-checking bench for suma_serial against an arithmetic reference model.
module tb_suma_serial;

  localparam int unsigned M = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, cin;
  logic [M-1:0] A, B;
  logic         busy, done, C, N, V, Z;
  logic [M-1:0] S;

  int n_cmp = 0;
  int n_err = 0;

  // Reference view of the published outputs {S, C, N, V, Z}.
  logic [M-1:0] exp_s;
  logic         exp_c, exp_n, exp_v, exp_z;

  suma_serial #(.M(M)) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .S    (S),
    .C    (C),
    .N    (N),
    .V    (V),
    .Z    (Z)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [M-1:0] rnd_m();
    logic [31:0] r;
    r = $urandom();
    return r[M-1:0];
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, ".S"}, 32'(S), 32'(exp_s));
    check_eq({tag, ".CNVZ"}, {28'd0, C, N, V, Z}, {28'd0, exp_c, exp_n, exp_v, exp_z});
  endtask

  // One full operation starting from IDLE: accept, M run edges, done, back to IDLE.
  task automatic do_op(input logic [M-1:0] a, input logic [M-1:0] b, input logic ci);
    logic [M:0]   total;
    logic [M-1:0] ns;
    logic         r;
    total = {1'b0, a} + {1'b0, b} + {{M{1'b0}}, ci};
    ns    = total[M-1:0];
    start = 1'b1;
    A     = a;
    B     = b;
    cin   = ci;
    @(posedge clk); #1;
    check_eq("accept_busy", {31'd0, busy}, 32'd1);
    check_eq("accept_done", {31'd0, done}, 32'd0);
    for (int k = 1; k <= M; k++) begin
      // Extra requests and operand changes during the run must have no effect.
      start = 1'b1;
      A     = rnd_m();
      B     = rnd_m();
      cin   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (k < M) begin
        check_eq("run_busy", {31'd0, busy}, 32'd1);
        check_eq("run_done", {31'd0, done}, 32'd0);
        if (k == 1) check_outputs("hold_run");
      end
    end
    exp_s = ns;
    exp_c = total[M];
    exp_n = ns[M-1];
    exp_v = (a[M-1] == b[M-1]) && (ns[M-1] != a[M-1]);
    exp_z = (ns == '0);
    check_eq("done_pulse", {30'd0, busy, done}, 32'd1);
    check_outputs("result");
    r     = 1'($urandom_range(0, 1));
    start = r;
    @(posedge clk); #1;
    check_eq("idle_after_done", {30'd0, busy, done}, 32'd0);
    check_outputs("hold_idle");
  endtask

  task automatic idle_cycles(input int n);
    start = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check_eq("idle_quiet", {30'd0, busy, done}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    cin   = 1'b0;
    exp_s = '0;
    exp_c = 1'b0;
    exp_n = 1'b0;
    exp_v = 1'b0;
    exp_z = 1'b0;
    #1;
    check_eq("reset_state", {25'd0, busy, done, S, C, N, V, Z}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors.
    do_op(4'b0011, 4'b0101, 1'b0);
    check_eq("vec1_S", 32'(S), 32'b1000);
    check_eq("vec1_flags", {28'd0, C, N, V, Z}, 32'b0110);
    idle_cycles(1);
    do_op(4'b1111, 4'b0001, 1'b0);
    check_eq("vec2_flags", {28'd0, C, N, V, Z}, 32'b1001);
    do_op(4'b0111, 4'b1000, 1'b0);
    check_eq("vec3_S", 32'(S), 32'b1111);
    do_op(4'b0000, 4'b1111, 1'b1);
    check_eq("vec4_SCZ", {27'd0, S, C, Z}, {27'd0, 4'b0000, 1'b1, 1'b1});
    idle_cycles(2);
    do_op(4'b0001, 4'b0001, 1'b0);
    check_eq("vec5_S", 32'(S), 32'b0010);
    idle_cycles(1);

    // Asynchronous reset in the middle of a run.
    start = 1'b1;
    A     = 4'b0110;
    B     = 4'b0011;
    cin   = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_reset", {25'd0, busy, done, S, C, N, V, Z}, 32'd0);
    repeat (2) begin
      @(posedge clk); #1;
      check_eq("reset_no_done", {30'd0, busy, done}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_s = '0;
    exp_c = 1'b0;
    exp_n = 1'b0;
    exp_v = 1'b0;
    exp_z = 1'b0;
    do_op(4'b0110, 4'b0011, 1'b0);
    check_eq("post_reset_SNV", {26'd0, S, N, V}, {26'd0, 4'b1001, 1'b1, 1'b1});

    // Back-to-back: start is re-asserted on the first IDLE edge after each DONE.
    for (int i = 0; i < 6; i++) do_op(rnd_m(), rnd_m(), 1'($urandom_range(0, 1)));

    // Random operations with random idle gaps.
    for (int i = 0; i < 40; i++) begin
      do_op(rnd_m(), rnd_m(), 1'($urandom_range(0, 1)));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
